// File: rtl/terminal_writer_if.sv
//==============================================================================
// Module      : terminal_writer_if
// Description : Character handshake and text-buffer port bundle for the
//               80x30 terminal writer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface terminal_writer_if;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic [11:0] text_addr;
   logic        text_write;
   logic [7:0]  text_in;
   logic [7:0]  text_out;

   // Master sources characters and owns the text buffer read data.
   modport master (
      output char_valid,
      output char_data,
      output text_out,
      input  char_ready,
      input  text_addr,
      input  text_write,
      input  text_in
   );

   modport slave (
      input  char_valid,
      input  char_data,
      input  text_out,
      output char_ready,
      output text_addr,
      output text_write,
      output text_in
   );
endinterface

`default_nettype wire

// File: rtl/terminal_writer.sv
//==============================================================================
// Module      : terminal_writer
// Description : Character stream front end for the text-mode terminal; keeps a
//               cursor, wraps lines and scrolls the buffer by in-place copy.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module terminal_writer #(
   parameter int          COLS  = 80,
   parameter int          ROWS  = 30,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic             clock,
   input  logic             reset_n,
   terminal_writer_if.slave bus,
   output logic [6:0]       cursor_x,
   output logic [4:0]       cursor_y,
   output logic             busy
);

   localparam logic [6:0]  c_XMAX        = 7'(COLS - 1);
   localparam logic [4:0]  c_YMAX        = 5'(ROWS - 1);
   localparam logic [11:0] c_COLS_W      = 12'(COLS);
   localparam logic [11:0] c_LAST        = 12'(COLS * ROWS - 1);
   localparam logic [11:0] c_SCROLL_LAST = 12'((ROWS - 1) * COLS - 1);

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_CLEAR_ALL = 3'd1,
      ST_IDLE      = 3'd2,
      ST_PUT       = 3'd3,
      ST_SCROLL_RD = 3'd4,
      ST_SCROLL_WR = 3'd5,
      ST_CLEAR_ROW = 3'd6
   } state_t;

   state_t      r_state;
   logic [6:0]  r_x;
   logic [4:0]  r_y;
   logic [11:0] r_idx;
   logic        r_bs;
   logic        r_ready;
   logic        r_busy;
   logic [11:0] r_addr;
   logic        r_write;
   logic [7:0]  r_din;

   logic [11:0] w_lin;
   logic        w_is_print;
   logic        w_accept;

   always_comb begin
      w_lin      = 12'(r_y) * c_COLS_W + 12'(r_x);
      w_is_print = (bus.char_data >= 8'h20) && (bus.char_data <= 8'h7E);
      w_accept   = bus.char_valid && r_ready;
   end

   // All bus outputs are registers, so nothing on the text port depends
   // combinationally on the incoming character handshake.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_INIT;
         r_x     <= 7'd0;
         r_y     <= 5'd0;
         r_idx   <= 12'd0;
         r_bs    <= 1'b0;
         r_ready <= 1'b0;
         r_busy  <= 1'b1;
         r_addr  <= 12'd0;
         r_write <= 1'b0;
         r_din   <= BLANK;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_state <= ST_CLEAR_ALL;
               r_idx   <= 12'd0;
               r_addr  <= 12'd0;
               r_din   <= BLANK;
               r_write <= 1'b1;
            end

            ST_CLEAR_ALL: begin
               if (r_idx == c_LAST) begin
                  r_x     <= 7'd0;
                  r_y     <= 5'd0;
                  r_write <= 1'b0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_idx  <= r_idx + 12'd1;
                  r_addr <= r_idx + 12'd1;
               end
            end

            ST_IDLE: begin
               if (w_accept) begin
                  if (w_is_print) begin
                     r_din   <= bus.char_data;
                     r_bs    <= 1'b0;
                     r_addr  <= w_lin;
                     r_write <= 1'b1;
                     r_ready <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= ST_PUT;
                  end else begin
                     case (bus.char_data)
                        8'h0D: r_x <= 7'd0;
                        8'h0A: begin
                           r_x <= 7'd0;
                           if (r_y != c_YMAX) begin
                              r_y <= r_y + 5'd1;
                           end else begin
                              r_idx   <= 12'd0;
                              r_addr  <= c_COLS_W;
                              r_ready <= 1'b0;
                              r_busy  <= 1'b1;
                              r_state <= ST_SCROLL_RD;
                           end
                        end
                        8'h08: begin
                           if (r_x != 7'd0) begin
                              r_x     <= r_x - 7'd1;
                              r_din   <= BLANK;
                              r_bs    <= 1'b1;
                              r_addr  <= w_lin - 12'd1;
                              r_write <= 1'b1;
                              r_ready <= 1'b0;
                              r_busy  <= 1'b1;
                              r_state <= ST_PUT;
                           end
                        end
                        8'h0C: begin
                           r_idx   <= 12'd0;
                           r_addr  <= 12'd0;
                           r_din   <= BLANK;
                           r_write <= 1'b1;
                           r_ready <= 1'b0;
                           r_busy  <= 1'b1;
                           r_state <= ST_CLEAR_ALL;
                        end
                        default: ;
                     endcase
                  end
               end
            end

            ST_PUT: begin
               r_write <= 1'b0;
               // Backspace already moved the cursor when it was accepted.
               if (r_bs || (r_x != c_XMAX)) begin
                  if (!r_bs) begin
                     r_x <= r_x + 7'd1;
                  end
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_y != c_YMAX) begin
                  r_x     <= 7'd0;
                  r_y     <= r_y + 5'd1;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_x     <= 7'd0;
                  r_idx   <= 12'd0;
                  r_addr  <= c_COLS_W;
                  r_state <= ST_SCROLL_RD;
               end
            end

            ST_SCROLL_RD: begin
               r_din   <= bus.text_out;
               r_addr  <= r_idx;
               r_write <= 1'b1;
               r_state <= ST_SCROLL_WR;
            end

            ST_SCROLL_WR: begin
               r_idx <= r_idx + 12'd1;
               if (r_idx == c_SCROLL_LAST) begin
                  r_addr  <= r_idx + 12'd1;
                  r_din   <= BLANK;
                  r_state <= ST_CLEAR_ROW;
               end else begin
                  r_addr  <= r_idx + 12'd1 + c_COLS_W;
                  r_write <= 1'b0;
                  r_state <= ST_SCROLL_RD;
               end
            end

            ST_CLEAR_ROW: begin
               if (r_idx == c_LAST) begin
                  r_write <= 1'b0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_idx  <= r_idx + 12'd1;
                  r_addr <= r_idx + 12'd1;
               end
            end

            default: begin
               r_write <= 1'b0;
               r_ready <= 1'b0;
               r_busy  <= 1'b1;
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   assign bus.char_ready = r_ready;
   assign bus.text_addr  = r_addr;
   assign bus.text_write = r_write;
   assign bus.text_in    = r_din;
   assign cursor_x       = r_x;
   assign cursor_y       = r_y;
   assign busy           = r_busy;

endmodule

`default_nettype wire

// File: doc/terminal_writer.md
Name: terminal_writer

Overview:
- Character-stream front end for the 80x30 text-mode terminal.
- Accepts bytes over a valid/ready handshake and maintains a cursor.
- Drives the terminal's text-buffer write port (text_addr/text_write/text_in) and reads back through text_out.
- Handles printable characters, CR, LF, backspace, form feed, line wrap, and hardware scroll-up by copying the buffer in place.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- BLANK, 8'h20, fill character for clear and scroll

Ports:
- clock  input  1  system clock; all state changes on posedge
- reset_n  input  1  asynchronous, active-low reset
- char_valid  input  1  char_data holds a byte to consume
- char_data  input  8  byte to display or interpret
- char_ready  output  1  block can accept a byte this cycle
- text_addr  output  12  buffer address to the terminal, row*COLS+col
- text_write  output  1  write strobe to the terminal
- text_in  output  8  write data to the terminal
- text_out  input  8  combinational read data from the terminal at text_addr
- cursor_x  output  7  cursor column, 0..COLS-1
- cursor_y  output  5  cursor row, 0..ROWS-1
- busy  output  1  high in every state except IDLE

Behaviour:
- States: INIT, CLEAR_ALL, IDLE, PUT, SCROLL_RD, SCROLL_WR, CLEAR_ROW.
- text_addr, text_write and text_in decode from state and registers only; there is no combinational path from char_valid or char_data.
- Reset (async, while reset_n=0):
  - state=INIT; cursor (0,0); scroll/clear index idx=0.
  - char_ready=0, text_write=0, busy=1.
- INIT: one cycle, then CLEAR_ALL.
- CLEAR_ALL: text_write=1, text_addr=idx, text_in=BLANK; idx steps 0..2399, one per cycle. After 2399: cursor (0,0), then IDLE. Total 2400 write cycles.
- IDLE: char_ready=1, text_write=0. A byte is accepted when char_valid && char_ready.
  - 0x20..0x7E: latch byte, go to PUT.
  - 0x0D: x=0; stay IDLE.
  - 0x0A: x=0. If y<ROWS-1, y=y+1 and stay IDLE; else idx=0 and go to SCROLL_RD.
  - 0x08:
    - x>0: x=x-1, latch BLANK, then PUT with the cursor not advancing.
    - x==0: no-op.
  - 0x0C: idx=0, go to CLEAR_ALL.
  - Any other byte: consumed and ignored.
- PUT (1 cycle): text_write=1, text_addr=y*80+x, text_in=latched byte. Then, except for backspace:
  - x<COLS-1: x=x+1, go to IDLE.
  - x==COLS-1 and y<ROWS-1: x=0, y=y+1, go to IDLE.
  - x==COLS-1 and y==ROWS-1: x=0, idx=0, go to SCROLL_RD.
- SCROLL_RD: text_addr=idx+80, text_write=0; capture text_out into a hold register at the clock edge; go to SCROLL_WR.
- SCROLL_WR: text_addr=idx, text_write=1, text_in=hold.
  - idx<2319: idx+1, back to SCROLL_RD.
  - idx==2319: idx=2320, go to CLEAR_ROW.
- CLEAR_ROW: text_write=1, text_addr=idx, text_in=BLANK for idx 2320..2399, then IDLE. Cursor stays at (0,29).
- Scroll length: 4640 + 80 = 4720 cycles.
- char_ready=0 in every non-IDLE state. A byte held valid during busy is taken on the first IDLE cycle.
- Arithmetic: idx 12 bits. text_addr = y*80+x computed to 12 bits; maximum value 2399, never out of range.
- Reset mid-scroll or mid-clear: abandons the operation immediately, then INIT→CLEAR_ALL. The partially copied buffer is fully overwritten.

Test Plan:
- Release reset -> 1 idle cycle, then 2400 writes of 0x20 to addr 0..2399. char_ready rises on cycle 2402; cursor (0,0).
- Send 'A' (0x41) then 'B' -> writes 0x41 at addr 0 and 0x42 at addr 1, each 2 cycles after acceptance; cursor (2,0).
- Cursor (79,5), send 'Z' -> write at addr 479; cursor (0,6). Then 0x08 at (0,6) -> no write, cursor unchanged.
- Preload row 1 with 0x31, cursor (3,29), send 0x0A:
  - 4720 busy cycles;
  - addr 0..79 now 0x31;
  - addr 2320..2399 = 0x20;
  - cursor (0,29); char_ready held 0 throughout.
- Cursor (10,3), send 0x08 -> write 0x20 at addr 249; cursor (9,3). Then send 0x0C -> 2400 blank writes; cursor (0,0).
- Assert reset_n=0 at scroll idx=1000 -> text_write=0 immediately. After release -> full 2400-cycle clear; cursor (0,0).
